alu_sequencer: RTL and testbench

- Initiator side of the 8-bit ALU interface.
- Accepts one 6502 data operation per request over a valid/ready handshake and drives the combinational ALU's operand, mode and carry-in inputs.
- Iterates multi-bit shifts through the ALU, and owns the processor status register P (NV1BDIZC), which it updates from ALU results.
- Sits between the instruction decoder/controller and the ALU; returns the result via a valid/ready response.

---
 rtl/alu_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: initiator side of the 8-bit ALU interface.
// Accepts one 6502 data operation per request, drives the combinational ALU,
// iterates multi-bit shifts through it and owns the status register P (NV1BDIZC).
module alu_sequencer #(
    parameter logic [7:0] RESET_P = 8'h34
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] p_out,
    input  logic       p_load,
    input  logic [7:0] p_in,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [4:0] alu_mode,
    output logic       alu_carry_in,
    input  logic [7:0] alu_out,
    input  logic       alu_carry_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] OP_ADC  = 4'd0;
    localparam logic [3:0] OP_SBC  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_ORA  = 4'd3;
    localparam logic [3:0] OP_EOR  = 4'd4;
    localparam logic [3:0] OP_CMP  = 4'd5;
    localparam logic [3:0] OP_ASL  = 4'd6;
    localparam logic [3:0] OP_ROL  = 4'd7;
    localparam logic [3:0] OP_LSR  = 4'd8;
    localparam logic [3:0] OP_ROR  = 4'd9;
    localparam logic [3:0] OP_INC  = 4'd10;
    localparam logic [3:0] OP_DEC  = 4'd11;
    localparam logic [3:0] OP_BIT  = 4'd12;
    localparam logic [3:0] OP_ASLN = 4'd13;
    localparam logic [3:0] OP_LSRN = 4'd14;
    localparam logic [3:0] OP_NOP  = 4'd15;

    localparam logic [4:0] MODE_ADD = 5'd0;
    localparam logic [4:0] MODE_AND = 5'd1;
    localparam logic [4:0] MODE_OR  = 5'd2;
    localparam logic [4:0] MODE_EOR = 5'd3;
    localparam logic [4:0] MODE_SR  = 5'd4;

    // Bits 5 and 4 of P are hard-wired to one.
    localparam logic [7:0] P_FIXED = 8'h30;

    logic [1:0] state_r;
    logic [3:0] op_r;
    logic [7:0] work_r;      // operand A, fed back as the work value for ASLN/LSRN
    logic [7:0] b_r;
    logic [2:0] count_r;
    logic [7:0] rsp_data_r;
    logic [7:0] p_r;

    logic [7:0] alu_a_s;
    logic [7:0] alu_b_s;
    logic [4:0] alu_mode_s;
    logic       alu_cin_s;
    logic       is_shift_n_s;
    logic       final_s;
    logic       pass_s;
    logic [7:0] result_s;
    logic       n_s;
    logic       z_s;
    logic       v_s;
    logic [7:0] p_next_s;

    assign req_ready    = (state_r == IDLE) && !reset;
    assign rsp_valid    = (state_r == RESP);
    assign rsp_data     = rsp_data_r;
    assign p_out        = p_r;
    assign alu_a        = alu_a_s;
    assign alu_b        = alu_b_s;
    assign alu_mode     = alu_mode_s;
    assign alu_carry_in = alu_cin_s;

    // ALU operand/mode drive: quiescent ADD of zeros outside EXEC.
    always_comb begin
        alu_a_s    = 8'h00;
        alu_b_s    = 8'h00;
        alu_mode_s = MODE_ADD;
        alu_cin_s  = 1'b0;
        if (state_r == EXEC) begin
            case (op_r)
                OP_ADC:  begin alu_a_s = work_r; alu_b_s = b_r;  alu_cin_s = p_r[0]; end
                OP_SBC:  begin alu_a_s = work_r; alu_b_s = ~b_r; alu_cin_s = p_r[0]; end
                OP_AND:  begin alu_a_s = work_r; alu_b_s = b_r;  alu_mode_s = MODE_AND; end
                OP_ORA:  begin alu_a_s = work_r; alu_b_s = b_r;  alu_mode_s = MODE_OR; end
                OP_EOR:  begin alu_a_s = work_r; alu_b_s = b_r;  alu_mode_s = MODE_EOR; end
                OP_CMP:  begin alu_a_s = work_r; alu_b_s = ~b_r; alu_cin_s = 1'b1; end
                OP_ASL:  begin alu_a_s = work_r; alu_b_s = work_r; end
                OP_ROL:  begin alu_a_s = work_r; alu_b_s = work_r; alu_cin_s = p_r[0]; end
                OP_LSR:  begin alu_a_s = work_r; alu_mode_s = MODE_SR; end
                OP_ROR:  begin alu_a_s = work_r; alu_mode_s = MODE_SR; alu_cin_s = p_r[0]; end
                OP_INC:  begin alu_a_s = work_r; alu_cin_s = 1'b1; end
                OP_DEC:  begin alu_a_s = work_r; alu_b_s = 8'hFF; end
                OP_BIT:  begin alu_a_s = work_r; alu_b_s = b_r;  alu_mode_s = MODE_AND; end
                OP_ASLN: begin alu_a_s = work_r; alu_b_s = work_r; end
                OP_LSRN: begin alu_a_s = work_r; alu_mode_s = MODE_SR; end
                default: begin alu_a_s = 8'h00; end
            endcase
        end else begin
            alu_a_s = 8'h00;
        end
    end

    // Result selection and next-P derivation for the final EXEC cycle.
    always_comb begin
        is_shift_n_s = (op_r == OP_ASLN) || (op_r == OP_LSRN);
        final_s      = !is_shift_n_s || (count_r <= 3'd1);
        pass_s       = (op_r == OP_NOP) || (is_shift_n_s && (count_r == 3'd0));
        result_s     = pass_s ? work_r : alu_out;
        n_s          = result_s[7];
        z_s          = (result_s == 8'h00);
        // Overflow is derived here from operands rather than taken from the ALU.
        v_s          = (work_r[7] == alu_b_s[7]) && (result_s[7] != work_r[7]);
        p_next_s     = p_r;
        case (op_r)
            OP_ADC, OP_SBC: begin
                p_next_s[7] = n_s; p_next_s[6] = v_s; p_next_s[1] = z_s; p_next_s[0] = alu_carry_out;
            end
            OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: begin
                p_next_s[7] = n_s; p_next_s[1] = z_s;
            end
            OP_CMP, OP_ASL, OP_ROL, OP_LSR, OP_ROR: begin
                p_next_s[7] = n_s; p_next_s[1] = z_s; p_next_s[0] = alu_carry_out;
            end
            OP_BIT: begin
                p_next_s[7] = b_r[7]; p_next_s[6] = b_r[6]; p_next_s[1] = z_s;
            end
            OP_ASLN, OP_LSRN: begin
                p_next_s[7] = n_s; p_next_s[1] = z_s;
                // A zero count shifts nothing out, so C keeps its value.
                if (count_r != 3'd0) begin
                    p_next_s[0] = alu_carry_out;
                end else begin
                    p_next_s[0] = p_r[0];
                end
            end
            default: begin
                p_next_s = p_r;
            end
        endcase
        p_next_s = p_next_s | P_FIXED;
    end

    // Sequencer state, operand latches, shift iteration, response and P register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            op_r       <= 4'd0;
            work_r     <= 8'h00;
            b_r        <= 8'h00;
            count_r    <= 3'd0;
            rsp_data_r <= 8'h00;
            p_r        <= RESET_P;
        end else begin
            case (state_r)
                IDLE: begin
                    if (p_load) begin
                        p_r <= p_in | P_FIXED;
                    end
                    if (req_valid) begin
                        op_r    <= req_op;
                        work_r  <= req_a;
                        b_r     <= req_b;
                        count_r <= req_b[2:0];
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    if (final_s) begin
                        rsp_data_r <= result_s;
                        p_r        <= p_next_s;
                        state_r    <= RESP;
                    end else begin
                        work_r  <= alu_out;
                        count_r <= count_r - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural model of the ALU.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_op = 4'd0;
    logic [7:0] req_a = 8'h00;
    logic [7:0] req_b = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [7:0] p_out;
    logic       p_load = 1'b0;
    logic [7:0] p_in = 8'h00;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [4:0] alu_mode;
    logic       alu_carry_in;
    logic [7:0] alu_out;
    logic       alu_carry_out;

    int n_checks = 0;
    int n_pass   = 0;

    alu_sequencer #(.RESET_P(8'h34)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .p_out(p_out), .p_load(p_load), .p_in(p_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out)
    );

    always #5 clk = ~clk;

    // Combinational ALU model: ADD/AND/OR/EOR/SR.
    always_comb begin
        logic [8:0] sum;
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
        alu_out = 8'h00;
        alu_carry_out = 1'b0;
        case (alu_mode)
            5'd0: begin alu_out = sum[7:0]; alu_carry_out = sum[8]; end
            5'd1: alu_out = alu_a & alu_b;
            5'd2: alu_out = alu_a | alu_b;
            5'd3: alu_out = alu_a ^ alu_b;
            5'd4: begin alu_out = {alu_carry_in, alu_a[7:1]}; alu_carry_out = alu_a[0]; end
            default: alu_out = 8'h00;
        endcase
    end

    // Issues one request (called just after a rising edge), waits for the
    // response with a cycle bound and completes the response handshake.
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic pl, input logic [7:0] pin,
                         output logic [7:0] d, output logic [7:0] p, output int lat);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; p_load = pl; p_in = pin;
        @(posedge clk); #1;
        req_valid = 1'b0; p_load = 1'b0;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        d = rsp_data;
        p = p_out;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, p_out} !== {1'b0, 1'b0, 8'h00, 8'h34})
            $display("FAIL reset_state got rr=%b rv=%b d=%h p=%h want 0 0 00 34", req_ready, rsp_valid, rsp_data, p_out);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, p_out} !== {1'b1, 1'b0, 8'h34})
            $display("FAIL reset_release got rr=%b rv=%b p=%h want 1 0 34", req_ready, rsp_valid, p_out);
        else n_pass++;
        n_checks++;
        if ({alu_mode, alu_a, alu_b, alu_carry_in} !== {5'd0, 8'h00, 8'h00, 1'b0})
            $display("FAIL idle_drive got m=%0d a=%h b=%h c=%b want 0 00 00 0", alu_mode, alu_a, alu_b, alu_carry_in);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    // One operation with its expected result, P and latency.
    task automatic run_check(input string name, input logic [3:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic pl, input logic [7:0] pin,
                             input logic [7:0] exp_d, input logic [7:0] exp_p, input int exp_lat);
        logic [7:0] d;
        logic [7:0] p;
        int lat;
        do_op(op, a, b, pl, pin, d, p, lat);
        n_checks++;
        if (d !== exp_d) $display("FAIL %s data got %h want %h", name, d, exp_d);
        else n_pass++;
        n_checks++;
        if (p !== exp_p) $display("FAIL %s p got %h want %h", name, p, exp_p);
        else n_pass++;
        n_checks++;
        if (lat != exp_lat) $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
        else n_pass++;
    endtask

    task automatic test_arith;
        run_check("adc",  4'd0, 8'h50, 8'h50, 1'b0, 8'h00, 8'hA0, 8'hF4, 2);
        run_check("sbc",  4'd1, 8'h05, 8'h03, 1'b1, 8'h01, 8'h02, 8'h31, 2);
        run_check("cmp",  4'd5, 8'h10, 8'h20, 1'b1, 8'h41, 8'hF0, 8'hF0, 2);
    endtask

    task automatic test_shift_bit;
        run_check("ror",  4'd9,  8'h01, 8'h00, 1'b1, 8'h01, 8'h80, 8'hB1, 2);
        run_check("lsr",  4'd8,  8'h01, 8'h00, 1'b0, 8'h00, 8'h00, 8'h33, 2);
        run_check("bit",  4'd12, 8'h0F, 8'hC0, 1'b0, 8'h00, 8'h00, 8'hF3, 2);
    endtask

    task automatic test_multishift;
        run_check("asln3", 4'd13, 8'h81, 8'h03, 1'b0, 8'h00, 8'h08, 8'h70, 4);
        run_check("asln0", 4'd13, 8'h81, 8'h00, 1'b1, 8'h01, 8'h81, 8'hB1, 2);
        run_check("lsrn5", 4'd14, 8'hF0, 8'h05, 1'b0, 8'h00, 8'h07, 8'h31, 6);
    endtask

    task automatic test_hold;
        int got;
        req_valid = 1'b1; req_op = 4'd4; req_a = 8'hFF; req_b = 8'h0F;
        @(posedge clk); #1;
        req_op = 4'd0; p_load = 1'b1; p_in = 8'hFF;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        if (got != 1 || rsp_data !== 8'hF0 || p_out !== 8'hB1)
            $display("FAIL hold_first got v=%0d d=%h p=%h want 1 F0 B1", got, rsp_data, p_out);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, req_ready, rsp_data, p_out} !== {1'b1, 1'b0, 8'hF0, 8'hB1})
                $display("FAIL hold_stable cyc %0d got rv=%b rr=%b d=%h p=%h want 1 0 F0 B1",
                         i, rsp_valid, req_ready, rsp_data, p_out);
            else n_pass++;
        end
        req_valid = 1'b0; p_load = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, req_ready, p_out} !== {1'b0, 1'b1, 8'hB1})
            $display("FAIL hold_release got rv=%b rr=%b p=%h want 0 1 B1", rsp_valid, req_ready, p_out);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        run_check("rol_pload", 4'd7,  8'h00, 8'h00, 1'b1, 8'h01, 8'h01, 8'h30, 2);
        run_check("inc",       4'd10, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 8'h32, 2);
        run_check("dec",       4'd11, 8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 8'hB0, 2);
        run_check("nop",       4'd15, 8'h5A, 8'h00, 1'b0, 8'h00, 8'h5A, 8'hB0, 2);
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_op = 4'd13; req_a = 8'hFF; req_b = 8'h07;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, req_ready, p_out} !== {1'b0, 1'b0, 8'h34})
            $display("FAIL reset_mid got rv=%b rr=%b p=%h want 0 0 34", rsp_valid, req_ready, p_out);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_mid_release got rr=%b want 1", req_ready);
        else n_pass++;
        @(posedge clk); #1;
        run_check("adc_after_reset", 4'd0, 8'h01, 8'h01, 1'b0, 8'h00, 8'h02, 8'h34, 2);
    endtask

    initial begin
        test_reset;
        test_arith;
        test_shift_bit;
        test_multishift;
        test_hold;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
